// File: rtl/rvx_tree_seq_pkg.sv
// Shared types and sizing helpers for the 4-ary tree reduction sequencer.
package rvx_tree_seq_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_t;

  function automatic int window_size(input int depth);
    return 1 << (2 * depth);
  endfunction

  // Must hold 1..WINDOW inclusive, hence one bit more than the slot index.
  function automatic int count_width(input int depth);
    return 2 * depth + 1;
  endfunction

endpackage

// File: rtl/rvx_tree_seq_out_slot.sv
// Output holding register: captures a window result on load and keeps it
// stable until the consumer takes it with out_valid & out_ready.
module rvx_tree_seq_out_slot #(
  parameter int BW_DATA = 8,
  parameter int CW      = 3
) (
  input  logic               clk,
  input  logic               rstp,
  input  logic               load,
  input  logic [BW_DATA-1:0] load_data,
  input  logic [CW-1:0]      load_count,
  output logic               out_valid,
  output logic [BW_DATA-1:0] out_data,
  output logic [CW-1:0]      out_count,
  input  logic               out_ready
);

  logic               valid_reg;
  logic [BW_DATA-1:0] data_reg;
  logic [CW-1:0]      count_reg;

  always_ff @(posedge clk) begin
    if (rstp) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      count_reg <= load_count;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_count = count_reg;

endmodule

// File: rtl/rvx_tree_reduce_sequencer.sv
// Sequencer for a 4-ary reduction tree: fills windows, pads on flush, waits
// out the tree latency and hands results downstream. Macro RVX_TREE_SEQ_FLUSH_EN enables flush.
module rvx_tree_reduce_sequencer
  import rvx_tree_seq_pkg::*;
#(
  parameter int                 DEPTH        = 1,
  parameter int                 BW_DATA      = 8,
  parameter int                 TREE_LATENCY = 1,
  parameter logic [BW_DATA-1:0] PAD_VALUE    = '0
) (
  input  logic                     clk,
  input  logic                     rstp,
  input  logic                     in_valid,
  input  logic [BW_DATA-1:0]       in_data,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [BW_DATA-1:0]       out_data,
  output logic [2*DEPTH:0]         out_count,
  input  logic                     out_ready,
  output logic                     tree_rstnn,
  output logic                     tree_enable,
  output logic                     tree_wvalid,
  output logic [BW_DATA-1:0]       tree_wdata,
  input  logic [BW_DATA-1:0]       tree_result
);

  localparam int WINDOW = window_size(DEPTH);
  localparam int CW     = count_width(DEPTH);
  localparam int SW     = 2 * DEPTH;
  localparam int WCW    = $clog2(TREE_LATENCY + 1);

  localparam logic [SW-1:0]  LAST_SLOT = SW'(WINDOW - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TREE_LATENCY);

  seq_state_t     state_reg, state_next;
  logic [SW-1:0]  cnt_reg, cnt_next;
  logic [CW-1:0]  rcnt_reg, rcnt_next;
  logic [WCW-1:0] wcnt_reg, wcnt_next;
  logic           load;
  logic           accept;

  assign tree_rstnn  = ~rstp;
  assign tree_enable = ~rstp;
  assign accept      = in_valid & in_ready;

`ifndef RVX_TREE_SEQ_FLUSH_EN
  logic flush_unused;
  assign flush_unused = flush;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rcnt_next   = rcnt_reg;
    wcnt_next   = wcnt_reg;
    load        = 1'b0;
    in_ready    = 1'b0;
    tree_wvalid = 1'b0;
    tree_wdata  = in_data;
    case (state_reg)
      ST_FILL: begin
        in_ready    = ~rstp;
        tree_wvalid = in_valid & ~rstp;
        if (accept) begin
          cnt_next  = cnt_reg + 1'b1;
          rcnt_next = rcnt_reg + 1'b1;
          if (cnt_reg == LAST_SLOT) state_next = ST_DRAIN;
        end
`ifdef RVX_TREE_SEQ_FLUSH_EN
        // A flush that coincides with the window-completing accept is moot.
        if (flush && state_next == ST_FILL && cnt_next != '0) state_next = ST_PAD;
`endif
      end
      ST_PAD: begin
        tree_wvalid = ~rstp;
        tree_wdata  = PAD_VALUE;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == LAST_SLOT) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Root settles TREE_LATENCY edges after the final write; capture one edge later.
        wcnt_next = wcnt_reg + 1'b1;
        if (wcnt_reg == WAIT_LAST) begin
          wcnt_next  = '0;
          load       = 1'b1;
          rcnt_next  = '0;
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_valid && out_ready) state_next = ST_FILL;
      end
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state_reg <= ST_FILL;
      cnt_reg   <= '0;
      rcnt_reg  <= '0;
      wcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rcnt_reg  <= rcnt_next;
      wcnt_reg  <= wcnt_next;
    end
  end

  rvx_tree_seq_out_slot #(
    .BW_DATA (BW_DATA),
    .CW      (CW)
  ) u_out_slot (
    .clk        (clk),
    .rstp       (rstp),
    .load       (load),
    .load_data  (tree_result),
    .load_count (rcnt_reg),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_ready  (out_ready)
  );

endmodule

// File: tb/tb_rvx_tree_reduce_sequencer.sv
// Directed bench for rvx_tree_reduce_sequencer with a max-of-four, latency-1 tree model.
module tb_rvx_tree_reduce_sequencer;

  logic       clk = 1'b0;
  logic       rstp;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic       out_ready;
  logic       tree_rstnn;
  logic       tree_enable;
  logic       tree_wvalid;
  logic [7:0] tree_wdata;
  logic [7:0] tree_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvx_tree_reduce_sequencer #(
    .DEPTH        (1),
    .BW_DATA      (8),
    .TREE_LATENCY (1),
    .PAD_VALUE    (8'd0)
  ) dut (
    .clk         (clk),
    .rstp        (rstp),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_ready   (out_ready),
    .tree_rstnn  (tree_rstnn),
    .tree_enable (tree_enable),
    .tree_wvalid (tree_wvalid),
    .tree_wdata  (tree_wdata),
    .tree_result (tree_result)
  );

  // Tree model: four slots written round-robin, root = registered max.
  logic [7:0] slot [4];
  logic [1:0] wptr;
  logic [7:0] mx01, mx23;
  assign mx01 = (slot[0] > slot[1]) ? slot[0] : slot[1];
  assign mx23 = (slot[2] > slot[3]) ? slot[2] : slot[3];

  always @(posedge clk) begin
    if (!tree_rstnn) begin
      wptr <= 2'd0;
      for (int i = 0; i < 4; i++) slot[i] <= 8'd0;
      tree_result <= 8'd0;
    end else begin
      if (tree_wvalid) begin
        slot[wptr] <= tree_wdata;
        wptr <= wptr + 2'd1;
      end
      tree_result <= (mx01 > mx23) ? mx01 : mx23;
    end
  end

  task automatic send(input logic [7:0] d, input logic f);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Returns the number of negedges until out_valid is seen, 99 on timeout.
  task automatic wait_out(output int k);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        k = i;
        return;
      end
    end
    k = 99;
  endtask

  task automatic test_reset();
    rstp = 1'b1; in_valid = 1'b1; in_data = 8'hAA; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || tree_wvalid !== 1'b0 || out_valid !== 1'b0 || tree_rstnn !== 1'b0 ||
          tree_enable !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: in_ready=%b wvalid=%b out_valid=%b rstnn=%b en=%b, required 0 0 0 0 0",
                 c, in_ready, tree_wvalid, out_valid, tree_rstnn, tree_enable);
      end
    end
    checks++;
    if (out_data !== 8'd0 || out_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: out_data=%0d out_count=%0d, required 0 0", out_data, out_count);
    end
    rstp = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || tree_rstnn !== 1'b1 || tree_enable !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b rstnn=%b en=%b, required 1 1 1", in_ready, tree_rstnn, tree_enable);
    end
    $display("reset: done");
  endtask

  task automatic test_full_window();
    int k;
    out_ready = 1'b1;
    send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0); send(8'd7, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    wait_out(k);
    checks++;
    if (k !== 2) begin
      errors++;
      $display("FAIL full_latency: out_valid after %0d cycles, required 2", k);
    end
    checks++;
    if (out_data !== 8'd9 || out_count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_result: data=%0d count=%0d in_ready=%b, required 9 4 0", out_data, out_count, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_return: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    $display("full window 3,9,1,7: data=9 count=4 latency=%0d", k);
  endtask

  task automatic test_backpressure();
    int k;
    out_ready = 1'b0;
    send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0); send(8'd7, 1'b0);
    idle();
    wait_out(k);
    checks++;
    if (k !== 2) begin
      errors++;
      $display("FAIL bp_latency: out_valid after %0d cycles, required 2", k);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd9 || out_count !== 3'd4 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: valid=%b data=%0d count=%0d in_ready=%b, required 1 9 4 0",
                 c, out_valid, out_data, out_count, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    $display("backpressure 5 cycles: result held, returned to fill");
  endtask

  task automatic test_flush();
    int k;
    out_ready = 1'b1;
    send(8'd5, 1'b0); send(8'd2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`ifdef RVX_TREE_SEQ_FLUSH_EN
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0 || tree_wvalid !== 1'b1 || tree_wdata !== 8'd0) begin
        errors++;
        $display("FAIL flush_pad%0d: in_ready=%b wvalid=%b wdata=%0d, required 0 1 0",
                 c, in_ready, tree_wvalid, tree_wdata);
      end
      @(negedge clk);
    end
    checks++;
    if (tree_wvalid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain: wvalid=%b in_ready=%b, required 0 0", tree_wvalid, in_ready);
    end
    wait_out(k);
    checks++;
    if (k !== 2 || out_data !== 8'd5 || out_count !== 3'd2) begin
      errors++;
      $display("FAIL flush_result: k=%0d data=%0d count=%0d, required 2 5 2", k, out_data, out_count);
    end
    $display("flush after 5,2: two pads, data=5 count=2");
`else
    checks++;
    if (in_ready !== 1'b1 || tree_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL noflush_ignored: in_ready=%b wvalid=%b, required 1 0", in_ready, tree_wvalid);
    end
    in_valid = 1'b1; in_data = 8'd4;
    send(8'd6, 1'b0);
    idle();
    wait_out(k);
    checks++;
    if (k !== 2 || out_data !== 8'd6 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL noflush_result: k=%0d data=%0d count=%0d, required 2 6 4", k, out_data, out_count);
    end
    $display("flush ignored: window 5,2,4,6 data=6 count=4");
`endif
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_return: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush_on_last();
    int k;
    send(8'd8, 1'b0); send(8'd6, 1'b0); send(8'd4, 1'b0); send(8'd2, 1'b1);
    idle();
    checks++;
    if (tree_wvalid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flushlast_nopad: wvalid=%b in_ready=%b, required 0 0", tree_wvalid, in_ready);
    end
    wait_out(k);
    checks++;
    if (k !== 2 || out_data !== 8'd8 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL flushlast_result: k=%0d data=%0d count=%0d, required 2 8 4", k, out_data, out_count);
    end
    @(negedge clk);
    $display("flush with 4th sample: no pad, data=8 count=4");
  endtask

  task automatic test_reset_in_drain();
    int k;
    send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0); send(8'd7, 1'b0);
    idle();
    rstp = 1'b1;
    @(negedge clk);
    rstp = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drainrst_state: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drainrst_quiet cyc%0d: out_valid=%b, required 0", c, out_valid);
      end
    end
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    idle();
    wait_out(k);
    checks++;
    if (k !== 2 || out_data !== 8'd4 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL drainrst_result: k=%0d data=%0d count=%0d, required 2 4 4", k, out_data, out_count);
    end
    @(negedge clk);
    $display("reset in drain: window dropped, then 1,2,3,4 data=4 count=4");
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_backpressure();
    test_flush();
    test_flush_on_last();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
